// File: rtl/htif_mailbox.sv
// htif_mailbox: snoops the core's store port for tohost verdict writes and
// console bytes. Produces a sticky pass/fail verdict with a frozen cycle count
// and buffers console bytes in a FIFO that is drained over a ready/valid port.
module htif_mailbox #(
   parameter int                          ADDR_W       = 32,
   parameter int                          DATA_W       = 32,
   parameter int                          NUM_TOHOST   = 3,
   parameter logic [NUM_TOHOST*ADDR_W-1:0] TOHOST_ADDRS = {32'h8017fffc, 32'h80003000, 32'h80001000},
   parameter logic [ADDR_W-1:0]           CONSOLE_ADDR = 32'h9a100000,
   parameter int                          FIFO_DEPTH   = 16,
   parameter int                          CNT_W        = 64,
   localparam int                         LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_req_i,
   input  logic              data_gnt_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   input  logic              clear_i,
   output logic              con_valid_o,
   output logic [7:0]        con_data_o,
   input  logic              con_ready_i,
   output logic [LVL_W-1:0]  con_level_o,
   output logic              con_overflow_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic [DATA_W-2:0] fail_code_o,
   output logic [CNT_W-1:0]  cycle_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DONE_PASS = 2'd1,
      DONE_FAIL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-2:0]   fail_code_q, fail_code_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [7:0]          mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0]    level;
   logic                overflow;

   logic store_ev;
   logic tohost_hit;
   logic con_hit;
   logic fifo_full;
   logic pop;
   logic push_ok;

   assign store_ev  = data_req_i & data_gnt_i & data_we_i;
   assign con_hit   = store_ev && (data_addr_i == CONSOLE_ADDR);
   assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
   assign pop       = con_valid_o & con_ready_i;
   assign push_ok   = con_hit && (!fifo_full || pop);

   // Match the store address against every tohost entry; all entries are equivalent
   always_comb begin
      tohost_hit = 1'b0;
      for (int i = 0; i < NUM_TOHOST; i++) begin
         if (data_addr_i == TOHOST_ADDRS[i*ADDR_W +: ADDR_W]) tohost_hit = 1'b1;
      end
   end

   // Verdict next state: clear wins, otherwise only the first nonzero tohost write in RUN counts
   always_comb begin
      state_d     = state_q;
      fail_code_d = fail_code_q;
      if (clear_i) begin
         state_d     = RUN;
         fail_code_d = '0;
      end else if (state_q == RUN && store_ev && tohost_hit && data_wdata_i != '0) begin
         if (data_wdata_i == DATA_W'(1)) begin
            state_d = DONE_PASS;
         end else begin
            state_d     = DONE_FAIL;
            fail_code_d = data_wdata_i[DATA_W-1:1];
         end
      end
   end

   // Verdict state and latched fail code
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RUN;
         fail_code_q <= '0;
      end else begin
         state_q     <= state_d;
         fail_code_q <= fail_code_d;
      end
   end

   // Cycle counter runs only in RUN, so it freezes at the value including the hit edge
   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Console FIFO storage and pointers; a full FIFO still accepts a push when a pop frees a slot
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= data_wdata_i[7:0];
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow flag for console bytes dropped on a full FIFO
   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         overflow <= 1'b0;
      end else if (con_hit && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   assign con_valid_o    = (level != '0);
   assign con_data_o     = con_valid_o ? mem[rd_ptr] : 8'h00;
   assign con_level_o    = level;
   assign con_overflow_o = overflow;
   assign done_o         = (state_q != RUN);
   assign pass_o         = (state_q == DONE_PASS);
   assign fail_o         = (state_q == DONE_FAIL);
   assign fail_code_o    = fail_code_q;
   assign cycle_count_o  = cnt_q;

endmodule

// File: doc/htif_mailbox.md
# htif_mailbox

Synthesizable host-interface monitor that snoops the core's data-memory store port for test-status ("tohost") and console writes. It decodes a parametrised set of tohost addresses into a sticky pass/fail verdict with a frozen cycle count. Console bytes are buffered in a FIFO drained over a ready/valid port. It sits beside the core in the simulation top and in FPGA builds, replacing bench-side monitoring.

## Interface
- ADDR_W, 32, data address width
- DATA_W, 32, store data width (≥9)
- NUM_TOHOST, 3, number of tohost addresses
- TOHOST_ADDRS, {32'h8017fffc, 32'h80003000, 32'h80001000}, packed NUM_TOHOST×ADDR_W list; entry 0 in LSBs
- CONSOLE_ADDR, 32'h9a100000, console byte address; must differ from every tohost address
- FIFO_DEPTH, 16, console FIFO entries; power of two, ≥2
- CNT_W, 64, cycle counter width
- Clocking: reset reset, synchronous, active-low; clock clk.
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- data_req_i  in  1  core data request
- data_gnt_i  in  1  memory grant; a store counts only when req&gnt&we
- data_we_i  in  1  store enable
- data_addr_i  in  ADDR_W  store address
- data_wdata_i  in  DATA_W  store data
- clear_i  in  1  restart monitor: clears verdict, counter, overflow flag
- con_valid_o  out  1  FIFO non-empty
- con_data_o  out  8  head byte
- con_ready_i  in  1  consumer accepts head
- con_level_o  out  $clog2(FIFO_DEPTH+1)  occupancy
- con_overflow_o  out  1  sticky: a console byte was dropped
- done_o  out  1  verdict valid
- pass_o  out  1  tohost value was 1
- fail_o  out  1  tohost value was nonzero and not 1
- fail_code_o  out  DATA_W-1  tohost value >> 1 on fail, else 0
- cycle_count_o  out  CNT_W  cycles since reset/clear, frozen at verdict

## Operation
- Store event: data_req_i & data_gnt_i & data_we_i in a cycle, sampled at the rising edge.
- Tohost hit: the store address equals any TOHOST_ADDRS entry. All entries are equivalent.
- Verdict FSM states:
  - RUN (reset state): a tohost hit with value 0 is ignored. Value 1 goes to DONE_PASS. Any other value goes to DONE_FAIL and latches fail_code_o = value >> 1.
  - DONE_PASS / DONE_FAIL: further tohost writes are ignored and the first nonzero write wins.
  - clear_i in any state goes to RUN.
- Only one store event can occur per cycle, so multiple tohost hits in one cycle are impossible.
- cycle_count_o: 0 at reset/clear. Increments by 1 each cycle in RUN and wraps modulo 2^CNT_W. It holds in DONE states.
- Console push: a store event to CONSOLE_ADDR pushes data_wdata_i[7:0]. Pushes are accepted in every FSM state.
- Console pop: con_valid_o & con_ready_i.
- Full FIFO, push without pop: the byte is dropped and con_overflow_o is set.
- Full FIFO, push with pop in the same cycle: both succeed and level is unchanged.
- Empty FIFO: there is no bypass. A pushed byte appears on con_data_o the next cycle.
- clear_i clears con_overflow_o but does not flush the FIFO.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter.

## Timing
- Reset values: con_valid_o=0, con_data_o=0, con_level_o=0, con_overflow_o=0, done_o=0, pass_o=0, fail_o=0, fail_code_o=0, cycle_count_o=0. The FSM is in RUN.
- Verdict latency is 1 cycle: for a store event sampled at edge t, done_o and pass_o/fail_o are high from the cycle after edge t.
- The count is frozen at its value after edge t. That edge still increments it, so the frozen value equals the number of RUN edges including the hit edge.
- The FIFO is registered: con_valid_o rises 1 cycle after the first push. con_level_o updates at the same edge as the push or pop.
- con_data_o is stable while con_valid_o & !con_ready_i.
- clear_i has priority over a simultaneous tohost hit; the hit is discarded. A simultaneous console push is still accepted. Outputs read reset values (except the FIFO) from the next cycle.
- Reset asserted mid-operation: all state, including FIFO contents, returns to reset values at the next edge.

## Test plan
- Reset release, then 10 idle cycles, then a store of 1 to 0x80001000 → done_o=pass_o=1 from the following cycle, fail_o=0, cycle_count_o=11 and frozen for 20 further cycles.
- Store 0 to 0x80003000, then 0x2B to 0x8017fffc → the first store causes no verdict; the second gives fail_o=1, fail_code_o=21. A later store of 1 → pass_o stays 0.
- Push 20 bytes 0x41..0x54 with con_ready_i=0, FIFO_DEPTH=16 → con_level_o=16, con_overflow_o=1. Draining yields 0x41..0x50 in order, then con_valid_o=0.
- Full FIFO with push and pop in the same cycle → level stays 16, no overflow. The new byte emerges last.
- Hit of value 1 in the same cycle as clear_i → no verdict, counter reads 0 then increments. Assert reset mid-drain → level=0 and con_valid_o=0 next cycle.
- Store to 0x80001000 with data_gnt_i=0, or with data_we_i=0 → no verdict. Store to an unlisted address → no effect.
